// File: rtl/rf_pkg.sv
// Shared constants and types for the write-back register file and its scoreboard.
package rf_pkg;

    localparam int unsigned RF_DATA_W   = 16;
    localparam int unsigned RF_ADDR_W   = 3;
    localparam int unsigned RF_NUM_REGS = 1 << RF_ADDR_W;

    typedef logic [RF_ADDR_W-1:0] rf_idx_t;

    // Non-zero when a write-back strobe targets the given index this cycle.
    function automatic logic wb_hits(input logic wb_en, input logic [31:0] wb_addr,
                                     input logic [31:0] idx);
        return wb_en && (wb_addr == idx);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits and combinational issue-stall generation.
// Define RF_BYPASS_EN to let a same-cycle write-back resolve a pending hazard.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_W = RF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              wb_en_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_a_i,
    input  logic [ADDR_W-1:0] rd_addr_b_i,
    input  logic              rd_use_a_i,
    input  logic              rd_use_b_i,
    input  logic              iss_valid_i,
    input  logic              iss_wr_i,
    input  logic [ADDR_W-1:0] iss_dest_i,
    output logic              stall_o
);

    localparam int unsigned NumRegs = 1 << ADDR_W;

    logic [NumRegs-1:0] busy_q;
    logic [NumRegs-1:0] busy_d;

    logic resolve_a;
    logic resolve_b;
    logic resolve_dest;
    logic haz_a;
    logic haz_b;
    logic haz_waw;
    logic issue_set;

    always_comb begin
`ifdef RF_BYPASS_EN
        resolve_a    = wb_hits(wb_en_i, 32'(wb_addr_i), 32'(rd_addr_a_i));
        resolve_b    = wb_hits(wb_en_i, 32'(wb_addr_i), 32'(rd_addr_b_i));
        resolve_dest = wb_hits(wb_en_i, 32'(wb_addr_i), 32'(iss_dest_i));
`else
        // Without bypass a busy register stays a hazard until its bit clears.
        resolve_a    = 1'b0;
        resolve_b    = 1'b0;
        resolve_dest = 1'b0;
`endif
        haz_a   = rd_use_a_i && busy_q[rd_addr_a_i] && !resolve_a;
        haz_b   = rd_use_b_i && busy_q[rd_addr_b_i] && !resolve_b;
        haz_waw = iss_wr_i && busy_q[iss_dest_i] && !resolve_dest;

        stall_o   = !reset_i && iss_valid_i && (haz_a || haz_b || haz_waw);
        issue_set = iss_valid_i && iss_wr_i && !stall_o;
    end

    always_comb begin
        busy_d = busy_q;
        if (wb_en_i) begin
            busy_d[wb_addr_i] = 1'b0;
        end
        // Applied after the clear so a same-register set wins.
        if (issue_set) begin
            busy_d[iss_dest_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/reg_file_wb.sv
// Two-read, one-write register file with registered reads and a hazard scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write-back data to the read ports.
module reg_file_wb
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic              rd_use_a,
    input  logic              rd_use_b,
    input  logic              iss_valid,
    input  logic              iss_wr,
    input  logic [ADDR_W-1:0] iss_dest,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              stall
);

    localparam int unsigned NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] rd_data_a_q;
    logic [DATA_W-1:0] rd_data_a_d;
    logic [DATA_W-1:0] rd_data_b_q;
    logic [DATA_W-1:0] rd_data_b_d;

    always_comb begin
        regs_d = regs_q;
        if (wb_en) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    always_comb begin
        rd_data_a_d = regs_q[rd_addr_a];
        rd_data_b_d = regs_q[rd_addr_b];
`ifdef RF_BYPASS_EN
        if (wb_hits(wb_en, 32'(wb_addr), 32'(rd_addr_a))) begin
            rd_data_a_d = wb_data;
        end
        if (wb_hits(wb_en, 32'(wb_addr), 32'(rd_addr_b))) begin
            rd_data_b_d = wb_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
        end else begin
            regs_q      <= regs_d;
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
        end
    end

    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk_i       (clk),
        .reset_i     (reset),
        .wb_en_i     (wb_en),
        .wb_addr_i   (wb_addr),
        .rd_addr_a_i (rd_addr_a),
        .rd_addr_b_i (rd_addr_b),
        .rd_use_a_i  (rd_use_a),
        .rd_use_b_i  (rd_use_b),
        .iss_valid_i (iss_valid),
        .iss_wr_i    (iss_wr),
        .iss_dest_i  (iss_dest),
        .stall_o     (stall)
    );

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb; expectations follow RF_BYPASS_EN.
module tb_reg_file_wb;
    import rf_pkg::*;

`ifdef RF_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 wb_en;
    rf_idx_t              wb_addr;
    logic [RF_DATA_W-1:0] wb_data;
    rf_idx_t              rd_addr_a;
    rf_idx_t              rd_addr_b;
    logic                 rd_use_a;
    logic                 rd_use_b;
    logic                 iss_valid;
    logic                 iss_wr;
    rf_idx_t              iss_dest;
    logic [RF_DATA_W-1:0] rd_data_a;
    logic [RF_DATA_W-1:0] rd_data_b;
    logic                 stall;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_file_wb dut (
        .clk       (clk),
        .reset     (reset),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_use_a  (rd_use_a),
        .rd_use_b  (rd_use_b),
        .iss_valid (iss_valid),
        .iss_wr    (iss_wr),
        .iss_dest  (iss_dest),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .stall     (stall)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wb_en     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        rd_use_a  = 1'b0;
        rd_use_b  = 1'b0;
        iss_valid = 1'b0;
        iss_wr    = 1'b0;
        iss_dest  = '0;
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input rf_idx_t a, input logic [RF_DATA_W-1:0] d);
        idle();
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
        cycle();
        idle();
    endtask

    task automatic issue_wr(input rf_idx_t d);
        idle();
        iss_valid = 1'b1;
        iss_wr    = 1'b1;
        iss_dest  = d;
        cycle();
        idle();
    endtask

    initial begin
        idle();
        reset     = 1'b1;
        rd_addr_a = '0;
        rd_addr_b = '0;
        cycle();
        cycle();
        check_eq("reset_rd_a", 32'(rd_data_a), 32'h0);
        check_eq("reset_rd_b", 32'(rd_data_b), 32'h0);
        check_eq("reset_stall", 32'(stall), 32'h0);
        reset = 1'b0;

        // Write then read back, including register 0.
        write(3'd3, 16'h1234);
        rd_addr_a = 3'd3;
        cycle();
        check_eq("rd_r3", 32'(rd_data_a), 32'h1234);
        write(3'd0, 16'h00AA);
        rd_addr_a = 3'd0;
        rd_addr_b = 3'd3;
        cycle();
        check_eq("rd_r0", 32'(rd_data_a), 32'h00AA);
        check_eq("rd_b_r3", 32'(rd_data_b), 32'h1234);

        // Same-cycle read of the write-back target.
        write(3'd5, 16'h1111);
        wb_en     = 1'b1;
        wb_addr   = 3'd5;
        wb_data   = 16'hBEEF;
        rd_addr_b = 3'd5;
        cycle();
        idle();
        check_eq("same_cyc_rd", 32'(rd_data_b), Byp ? 32'hBEEF : 32'h1111);
        cycle();
        check_eq("rd_r5_after", 32'(rd_data_b), 32'hBEEF);

        // RAW hazard on R2.
        iss_valid = 1'b1;
        iss_wr    = 1'b1;
        iss_dest  = 3'd2;
        #1;
        check_eq("issue_r2_nostall", 32'(stall), 32'h0);
        cycle();
        idle();
        iss_valid = 1'b1;
        rd_use_a  = 1'b1;
        rd_addr_a = 3'd2;
        #1;
        check_eq("raw_stall_1", 32'(stall), 32'h1);
        cycle();
        check_eq("raw_stall_2", 32'(stall), 32'h1);
        rd_use_a = 1'b0;
        rd_use_b = 1'b1;
        rd_addr_b = 3'd2;
        #1;
        check_eq("raw_stall_b", 32'(stall), 32'h1);
        rd_use_b = 1'b0;
        #1;
        check_eq("unused_src_nostall", 32'(stall), 32'h0);
        rd_use_a = 1'b1;
        wb_en    = 1'b1;
        wb_addr  = 3'd2;
        wb_data  = 16'h2222;
        #1;
        check_eq("raw_wb_cycle", 32'(stall), Byp ? 32'h1 - 32'h1 : 32'h1);
        cycle();
        wb_en = 1'b0;
        #1;
        check_eq("raw_after_wb", 32'(stall), 32'h0);
        idle();
        cycle();
        check_eq("rd_r2", 32'(rd_data_a), 32'h2222);

        // WAW hazard on R6, then a write-back and reissue in the same cycle.
        issue_wr(3'd6);
        iss_valid = 1'b1;
        iss_wr    = 1'b1;
        iss_dest  = 3'd6;
        #1;
        check_eq("waw_stall", 32'(stall), 32'h1);
        iss_valid = 1'b0;
        #1;
        check_eq("no_valid_nostall", 32'(stall), 32'h0);
        iss_valid = 1'b1;
        wb_en     = 1'b1;
        wb_addr   = 3'd6;
        wb_data   = 16'h6666;
        #1;
        check_eq("waw_wb_cycle", 32'(stall), Byp ? 32'h0 : 32'h1);
        cycle();
        wb_en = 1'b0;
        #1;
        // Bypass: the reissue went through and R6 is busy again; otherwise it cleared.
        check_eq("waw_next", 32'(stall), Byp ? 32'h1 : 32'h0);
        write(3'd6, 16'h6666);
        iss_valid = 1'b1;
        iss_wr    = 1'b1;
        iss_dest  = 3'd6;
        #1;
        check_eq("r6_clear", 32'(stall), 32'h0);
        idle();

        // Set and clear of R4 in one cycle: set wins.
        iss_valid = 1'b1;
        iss_wr    = 1'b1;
        iss_dest  = 3'd4;
        wb_en     = 1'b1;
        wb_addr   = 3'd4;
        wb_data   = 16'h4444;
        #1;
        check_eq("r4_set_nostall", 32'(stall), 32'h0);
        cycle();
        idle();
        iss_valid = 1'b1;
        rd_use_b  = 1'b1;
        rd_addr_b = 3'd4;
        #1;
        check_eq("r4_still_busy", 32'(stall), 32'h1);
        write(3'd4, 16'h4444);

        // Reset mid-operation clears data and scoreboard.
        issue_wr(3'd1);
        issue_wr(3'd6);
        write(3'd7, 16'hFFFF);
        iss_valid = 1'b1;
        rd_use_a  = 1'b1;
        rd_addr_a = 3'd1;
        #1;
        check_eq("r1_busy", 32'(stall), 32'h1);
        reset     = 1'b1;
        rd_use_b  = 1'b1;
        rd_addr_b = 3'd6;
        iss_wr    = 1'b1;
        iss_dest  = 3'd6;
        wb_en     = 1'b1;
        wb_addr   = 3'd3;
        wb_data   = 16'h5555;
        #1;
        check_eq("stall_in_reset", 32'(stall), 32'h0);
        cycle();
        reset = 1'b0;
        idle();
        check_eq("post_rst_rd_a", 32'(rd_data_a), 32'h0);
        check_eq("post_rst_rd_b", 32'(rd_data_b), 32'h0);
        rd_addr_a = 3'd7;
        rd_addr_b = 3'd3;
        cycle();
        check_eq("post_rst_r7", 32'(rd_data_a), 32'h0);
        check_eq("post_rst_r3", 32'(rd_data_b), 32'h0);
        iss_valid = 1'b1;
        iss_wr    = 1'b1;
        iss_dest  = 3'd6;
        rd_use_a  = 1'b1;
        rd_addr_a = 3'd1;
        rd_use_b  = 1'b1;
        rd_addr_b = 3'd6;
        #1;
        check_eq("post_rst_nostall", 32'(stall), 32'h0);
        idle();
        write(3'd1, 16'h0101);
        rd_addr_a = 3'd1;
        iss_valid = 1'b1;
        rd_use_a  = 1'b1;
        #1;
        check_eq("plain_wb_nostall", 32'(stall), 32'h0);
        cycle();
        idle();
        check_eq("rd_r1", 32'(rd_data_a), 32'h0101);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
